// File: rtl/b_bus_reg_bank.sv
// Register bank with a registered B-bus read port, a C-bus write port and a
// per-register increment path. Unmapped or masked selects are ignored and flagged on sel_err.
module b_bus_reg_bank #(
  parameter int                 WIDTH    = 16,
  parameter int                 NREGS    = 7,
  parameter int                 SEL_W    = 3,
  parameter logic [NREGS-1:0]   INC_MASK = 7'b0000001
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             b_en,
  input  logic [SEL_W-1:0] b_sel,
  input  logic             wr_en,
  input  logic [SEL_W-1:0] wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             inc_en,
  input  logic [SEL_W-1:0] inc_sel,
  output logic [WIDTH-1:0] B_bus,
  output logic             b_valid,
  output logic             sel_err
);

  logic [WIDTH-1:0] regs      [NREGS];
  logic [WIDTH-1:0] regs_next [NREGS];
  logic [NREGS-1:0] wr_hit;
  logic [NREGS-1:0] inc_hit;
  logic [NREGS-1:0] b_hit;
  logic [WIDTH-1:0] b_next;
  logic             b_ok;
  logic             any_bad;

  // One-hot decodes only cover mapped registers, so an empty decode means a bad select.
  always_comb begin
    wr_hit  = '0;
    inc_hit = '0;
    b_hit   = '0;
    for (int i = 0; i < NREGS; i++) begin
      wr_hit[i]  = wr_en && (wr_sel == SEL_W'(i));
      inc_hit[i] = inc_en && (inc_sel == SEL_W'(i)) && INC_MASK[i];
      b_hit[i]   = b_en && (b_sel == SEL_W'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_next[i] = regs[i];
      if (wr_hit[i]) begin
        regs_next[i] = wr_data;
      end else if (inc_hit[i]) begin
        regs_next[i] = regs[i] + WIDTH'(1);
      end
    end
  end

  // The read port samples the next-state value so same-cycle writes/increments forward.
  always_comb begin
    b_next = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (b_hit[i]) begin
        b_next = regs_next[i];
      end
    end
  end

  assign b_ok    = |b_hit;
  assign any_bad = (wr_en && !(|wr_hit)) || (inc_en && !(|inc_hit)) || (b_en && !b_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= regs_next[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      B_bus   <= '0;
      b_valid <= 1'b0;
      sel_err <= 1'b0;
    end else begin
      if (b_ok) begin
        B_bus <= b_next;
      end
      b_valid <= b_ok;
      sel_err <= any_bad;
    end
  end

endmodule

// File: tb/tb_b_bus_reg_bank.sv
// Self-checking bench for b_bus_reg_bank: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_b_bus_reg_bank;

  localparam int WIDTH = 16;
  localparam int NREGS = 7;
  localparam int SEL_W = 3;
  localparam logic [NREGS-1:0] MASK = 7'b0000001;

  logic             clk;
  logic             rst_n;
  logic             b_en;
  logic [SEL_W-1:0] b_sel;
  logic             wr_en;
  logic [SEL_W-1:0] wr_sel;
  logic [WIDTH-1:0] wr_data;
  logic             inc_en;
  logic [SEL_W-1:0] inc_sel;
  logic [WIDTH-1:0] B_bus;
  logic             b_valid;
  logic             sel_err;

  int tests_run;
  int tests_failed;

  logic [WIDTH-1:0] mdl [NREGS];
  logic [WIDTH-1:0] mdl_b;
  logic             mdl_v;
  logic             mdl_err;

  b_bus_reg_bank #(
    .WIDTH(WIDTH), .NREGS(NREGS), .SEL_W(SEL_W), .INC_MASK(MASK)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .b_en(b_en), .b_sel(b_sel),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .inc_en(inc_en), .inc_sel(inc_sel),
    .B_bus(B_bus), .b_valid(b_valid), .sel_err(sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Applies one cycle of stimulus, advances the reference model, returns 1 time unit after the edge.
  task automatic drive_cycle(input logic be, input logic [SEL_W-1:0] bs,
                             input logic we, input logic [SEL_W-1:0] ws,
                             input logic [WIDTH-1:0] wd,
                             input logic ie, input logic [SEL_W-1:0] isel);
    logic [WIDTH-1:0] nr [NREGS];
    logic wok, iok, bok;
    b_en = be; b_sel = bs; wr_en = we; wr_sel = ws; wr_data = wd;
    inc_en = ie; inc_sel = isel;
    @(posedge clk);
    wok = we && (int'(ws) < NREGS);
    iok = ie && (int'(isel) < NREGS) && (((MASK >> isel) & 1) != 0);
    bok = be && (int'(bs) < NREGS);
    nr = mdl;
    if (iok) nr[isel] = mdl[isel] + 16'd1;
    if (wok) nr[ws] = wd;
    if (bok) mdl_b = nr[bs];
    mdl_v   = bok;
    mdl_err = (be && !bok) || (we && !wok) || (ie && !iok);
    mdl = nr;
    #1;
  endtask

  task automatic idle_cycle();
    drive_cycle(1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < NREGS; i++) begin
      drive_cycle(1'b1, SEL_W'(i), 1'b1, SEL_W'(i), 16'hA5A5, 1'b0, 3'd0);
    end
    tests_run++;
    if (B_bus !== 16'hA5A5 || b_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL preload: B_bus=%h b_valid=%b, want A5A5/1", B_bus, b_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (B_bus !== 16'h0 || b_valid !== 1'b0 || sel_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: B_bus=%h b_valid=%b sel_err=%b, want 0/0/0", B_bus, b_valid, sel_err);
    end
    for (int i = 0; i < NREGS; i++) mdl[i] = '0;
    mdl_b = '0; mdl_v = 1'b0; mdl_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NREGS; i++) begin
      drive_cycle(1'b1, SEL_W'(i), 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
      tests_run++;
      if (B_bus !== 16'h0 || b_valid !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL reg_after_reset[%0d]: B_bus=%h b_valid=%b, want 0000/1", i, B_bus, b_valid);
      end
    end
  endtask

  task automatic test_write_read();
    drive_cycle(1'b0, 3'd0, 1'b1, 3'd3, 16'h1234, 1'b0, 3'd0);
    tests_run++;
    if (b_valid !== 1'b0 || sel_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL write_only: b_valid=%b sel_err=%b, want 0/0", b_valid, sel_err);
    end
    drive_cycle(1'b1, 3'd3, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
    tests_run++;
    if (B_bus !== 16'h1234 || b_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL read_r3: B_bus=%h b_valid=%b, want 1234/1", B_bus, b_valid);
    end
    idle_cycle();
    tests_run++;
    if (B_bus !== 16'h1234 || b_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL valid_pulse: B_bus=%h b_valid=%b, want 1234/0", B_bus, b_valid);
    end
  endtask

  task automatic test_forwarding();
    drive_cycle(1'b1, 3'd2, 1'b1, 3'd2, 16'hBEEF, 1'b0, 3'd0);
    tests_run++;
    if (B_bus !== 16'hBEEF || b_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL write_forward: B_bus=%h b_valid=%b, want BEEF/1", B_bus, b_valid);
    end
  endtask

  task automatic test_increment_wrap();
    drive_cycle(1'b0, 3'd0, 1'b1, 3'd0, 16'hFFFF, 1'b0, 3'd0);
    drive_cycle(1'b1, 3'd0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd0);
    tests_run++;
    if (B_bus !== 16'h0000 || b_valid !== 1'b1 || sel_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL inc_wrap_forward: B_bus=%h b_valid=%b sel_err=%b, want 0000/1/0", B_bus, b_valid, sel_err);
    end
    drive_cycle(1'b1, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
    tests_run++;
    if (B_bus !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL pc_after_wrap: B_bus=%h, want 0000", B_bus);
    end
    drive_cycle(1'b0, 3'd0, 1'b1, 3'd3, 16'h5555, 1'b0, 3'd0);
    drive_cycle(1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd3);
    tests_run++;
    if (sel_err !== 1'b1 || b_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL masked_inc: sel_err=%b b_valid=%b, want 1/0", sel_err, b_valid);
    end
    drive_cycle(1'b1, 3'd3, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
    tests_run++;
    if (B_bus !== 16'h5555 || sel_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL masked_inc_hold: B_bus=%h sel_err=%b, want 5555/0", B_bus, sel_err);
    end
  endtask

  task automatic test_collision();
    drive_cycle(1'b1, 3'd0, 1'b1, 3'd0, 16'h0010, 1'b1, 3'd0);
    tests_run++;
    if (B_bus !== 16'h0010) begin
      tests_failed++;
      $display("[TB] FAIL collision_forward: B_bus=%h, want 0010", B_bus);
    end
    drive_cycle(1'b0, 3'd0, 1'b1, 3'd1, 16'h7777, 1'b1, 3'd0);
    drive_cycle(1'b1, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
    tests_run++;
    if (B_bus !== 16'h0011) begin
      tests_failed++;
      $display("[TB] FAIL split_inc: B_bus=%h, want 0011", B_bus);
    end
    drive_cycle(1'b1, 3'd1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
    tests_run++;
    if (B_bus !== 16'h7777) begin
      tests_failed++;
      $display("[TB] FAIL split_write: B_bus=%h, want 7777", B_bus);
    end
  endtask

  task automatic test_bad_select();
    drive_cycle(1'b1, 3'd3, 1'b1, 3'd3, 16'h1234, 1'b0, 3'd0);
    drive_cycle(1'b1, 3'd7, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
    tests_run++;
    if (B_bus !== 16'h1234 || b_valid !== 1'b0 || sel_err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL bad_read: B_bus=%h b_valid=%b sel_err=%b, want 1234/0/1", B_bus, b_valid, sel_err);
    end
    idle_cycle();
    tests_run++;
    if (sel_err !== 1'b0 || B_bus !== 16'h1234) begin
      tests_failed++;
      $display("[TB] FAIL err_not_sticky: sel_err=%b B_bus=%h, want 0/1234", sel_err, B_bus);
    end
    drive_cycle(1'b1, 3'd4, 1'b1, 3'd7, 16'hDEAD, 1'b0, 3'd0);
    tests_run++;
    if (sel_err !== 1'b1 || b_valid !== 1'b1 || B_bus !== mdl_b) begin
      tests_failed++;
      $display("[TB] FAIL bad_write_good_read: sel_err=%b b_valid=%b B_bus=%h, want 1/1/%h", sel_err, b_valid, B_bus, mdl_b);
    end
  endtask

  task automatic test_random();
    logic [SEL_W-1:0] isel;
    for (int n = 0; n < 300; n++) begin
      isel = ($urandom_range(0, 2) == 0) ? SEL_W'($urandom_range(0, 7)) : 3'd0;
      drive_cycle(1'($urandom), SEL_W'($urandom_range(0, 7)),
                  1'($urandom), SEL_W'($urandom_range(0, 7)), 16'($urandom),
                  1'($urandom), isel);
      tests_run++;
      if (B_bus !== mdl_b || b_valid !== mdl_v || sel_err !== mdl_err) begin
        tests_failed++;
        $display("[TB] FAIL random[%0d]: B_bus=%h b_valid=%b sel_err=%b, want %h/%b/%b",
                 n, B_bus, b_valid, sel_err, mdl_b, mdl_v, mdl_err);
      end
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    for (int i = 0; i < NREGS; i++) mdl[i] = '0;
    mdl_b = '0; mdl_v = 1'b0; mdl_err = 1'b0;
    b_en = 1'b0; b_sel = '0; wr_en = 1'b0; wr_sel = '0; wr_data = '0;
    inc_en = 1'b0; inc_sel = '0;
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    test_reset();
    test_write_read();
    test_forwarding();
    test_increment_wrap();
    test_collision();
    test_bad_select();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
